// File: rtl/coldstore_sample_ctrl.sv
// Sample sequencer and climate controller: periodic DHT11 reads with timeout/retry, range check, hysteresis actuators.
// Latency: accepted sample visible one cycle after CHECK; data_valid and actuator changes share that cycle.
module coldstore_sample_ctrl #(
    parameter int unsigned SAMPLE_CYC    = 200_000_000,
    parameter int unsigned TIMEOUT_CYC   = 3_000_000,
    parameter int unsigned RETRY_GAP_CYC = 100_000_000,
    parameter int unsigned MAX_FAIL      = 3,
    parameter logic [7:0]  TEMP_SET      = 8'd25,
    parameter logic [7:0]  TEMP_HYST     = 8'd2,
    parameter logic [7:0]  HUM_SET       = 8'd50,
    parameter logic [7:0]  HUM_HYST      = 8'd5,
    parameter int unsigned MIN_DWELL     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       force_sample,
    output logic       sensor_start,
    input  logic       sensor_ready,
    input  logic [7:0] sensor_temp,
    input  logic [7:0] sensor_hum,
    output logic [7:0] temp_out,
    output logic [7:0] hum_out,
    output logic       data_valid,
    output logic       sensor_fault,
    output logic       fan_on,
    output logic       hum_on
);

    localparam int CW = 32;
    localparam int FW = (MAX_FAIL < 2) ? 1 : $clog2(MAX_FAIL + 1);
    localparam int DW = (MIN_DWELL < 2) ? 1 : $clog2(MIN_DWELL + 1);

    typedef enum logic [2:0] {
        S_WAIT,
        S_START,
        S_BUSY,
        S_CHECK,
        S_GAP
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      hold_temp_q;
    logic [7:0]      hold_hum_q;
    logic [FW-1:0]   fail_q;
    logic [DW-1:0]   dwell_fan_q;
    logic [DW-1:0]   dwell_hum_q;
    logic            sensor_start_q;
    logic [7:0]      temp_out_q;
    logic [7:0]      hum_out_q;
    logic            data_valid_q;
    logic            fault_q;
    logic            fan_on_q;
    logic            hum_on_q;

    logic            accept_d;
    logic            fail_evt_d;
    logic [FW-1:0]   fail_d;
    logic            fan_tgt_d;
    logic            hum_tgt_d;
    logic            fan_tog_d;
    logic            hum_tog_d;
    logic [DW-1:0]   dwell_fan_inc_d;
    logic [DW-1:0]   dwell_hum_inc_d;
    logic [8:0]      t9;
    logic [8:0]      h9;

    always_comb begin
        t9 = {1'b0, hold_temp_q};
        h9 = {1'b0, hold_hum_q};
        accept_d = (hold_temp_q <= 8'd50) && (hold_hum_q >= 8'd20) && (hold_hum_q <= 8'd90);

        fail_evt_d = ((state_q == S_BUSY) && !sensor_ready && (cnt_q == CW'(TIMEOUT_CYC - 1)))
                   || ((state_q == S_CHECK) && !accept_d);
        fail_d = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + FW'(1);

        fan_tgt_d = (t9 > ({1'b0, TEMP_SET} + {1'b0, TEMP_HYST}))
                  || (fan_on_q && !(t9 < {1'b0, TEMP_SET}));
        hum_tgt_d = ((h9 + {1'b0, HUM_HYST}) < {1'b0, HUM_SET})
                  || (hum_on_q && !(h9 > {1'b0, HUM_SET}));

        // Leaving fail-safe is not held back by dwell: the fault cleared the dwell history.
        fan_tog_d = (fan_tgt_d != fan_on_q) && (fault_q || (dwell_fan_q >= DW'(MIN_DWELL)));
        hum_tog_d = (hum_tgt_d != hum_on_q) && (fault_q || (dwell_hum_q >= DW'(MIN_DWELL)));

        dwell_fan_inc_d = (dwell_fan_q >= DW'(MIN_DWELL)) ? dwell_fan_q : dwell_fan_q + DW'(1);
        dwell_hum_inc_d = (dwell_hum_q >= DW'(MIN_DWELL)) ? dwell_hum_q : dwell_hum_q + DW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_WAIT;
            cnt_q          <= '0;
            hold_temp_q    <= '0;
            hold_hum_q     <= '0;
            fail_q         <= '0;
            dwell_fan_q    <= DW'(MIN_DWELL);
            dwell_hum_q    <= DW'(MIN_DWELL);
            sensor_start_q <= 1'b0;
            temp_out_q     <= '0;
            hum_out_q      <= '0;
            data_valid_q   <= 1'b0;
            fault_q        <= 1'b0;
            fan_on_q       <= 1'b0;
            hum_on_q       <= 1'b0;
        end else begin
            sensor_start_q <= 1'b0;
            data_valid_q   <= 1'b0;
            case (state_q)
                S_WAIT: begin
                    if (force_sample || (cnt_q == CW'(SAMPLE_CYC - 1))) begin
                        state_q        <= S_START;
                        cnt_q          <= '0;
                        sensor_start_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_START: begin
                    state_q <= S_BUSY;
                    cnt_q   <= '0;
                end
                S_BUSY: begin
                    if (sensor_ready) begin
                        hold_temp_q <= sensor_temp;
                        hold_hum_q  <= sensor_hum;
                        state_q     <= S_CHECK;
                    end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                        state_q <= S_GAP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_CHECK: begin
                    cnt_q <= '0;
                    if (accept_d) begin
                        state_q      <= S_WAIT;
                        temp_out_q   <= hold_temp_q;
                        hum_out_q    <= hold_hum_q;
                        data_valid_q <= 1'b1;
                        fail_q       <= '0;
                        fault_q      <= 1'b0;
                        if (fan_tog_d) begin
                            fan_on_q    <= fan_tgt_d;
                            dwell_fan_q <= '0;
                        end else begin
                            dwell_fan_q <= dwell_fan_inc_d;
                        end
                        if (hum_tog_d) begin
                            hum_on_q    <= hum_tgt_d;
                            dwell_hum_q <= '0;
                        end else begin
                            dwell_hum_q <= dwell_hum_inc_d;
                        end
                    end else begin
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt_q == CW'(RETRY_GAP_CYC - 1)) begin
                        state_q        <= S_START;
                        cnt_q          <= '0;
                        sensor_start_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= S_WAIT;
                    cnt_q   <= '0;
                end
            endcase

            // Fail-safe: cool and stop humidifying when the sensor cannot be trusted.
            if (fail_evt_d) begin
                fail_q <= fail_d;
                if (fail_d == FW'(MAX_FAIL)) begin
                    fault_q     <= 1'b1;
                    fan_on_q    <= 1'b1;
                    hum_on_q    <= 1'b0;
                    dwell_fan_q <= '0;
                    dwell_hum_q <= '0;
                end
            end
        end
    end

    assign sensor_start = sensor_start_q;
    assign temp_out     = temp_out_q;
    assign hum_out      = hum_out_q;
    assign data_valid   = data_valid_q;
    assign sensor_fault = fault_q;
    assign fan_on       = fan_on_q;
    assign hum_on       = hum_on_q;

endmodule

// File: tb/tb_coldstore_sample_ctrl.sv
// Directed bench for coldstore_sample_ctrl with shortened timing parameters.
module tb_coldstore_sample_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       force_sample;
    logic       sensor_start;
    logic       sensor_ready;
    logic [7:0] sensor_temp;
    logic [7:0] sensor_hum;
    logic [7:0] temp_out;
    logic [7:0] hum_out;
    logic       data_valid;
    logic       sensor_fault;
    logic       fan_on;
    logic       hum_on;

    int checks = 0;
    int errors = 0;
    bit dv_seen;

    always #5 clk = ~clk;

    coldstore_sample_ctrl #(
        .SAMPLE_CYC   (100),
        .TIMEOUT_CYC  (20),
        .RETRY_GAP_CYC(10),
        .MAX_FAIL     (3),
        .MIN_DWELL    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .force_sample(force_sample),
        .sensor_start(sensor_start),
        .sensor_ready(sensor_ready),
        .sensor_temp (sensor_temp),
        .sensor_hum  (sensor_hum),
        .temp_out    (temp_out),
        .hum_out     (hum_out),
        .data_valid  (data_valid),
        .sensor_fault(sensor_fault),
        .fan_on      (fan_on),
        .hum_on      (hum_on)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Edges until sensor_start is seen high (#1 after the edge); -1 if it never comes.
    task automatic wait_start(output int n);
        n = -1;
        for (int i = 1; i <= 150; i++) begin
            @(posedge clk);
            #1;
            if (data_valid) dv_seen = 1'b1;
            if (sensor_start) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (data_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic force_read(input string tag);
        force_sample = 1'b1;
        @(posedge clk);
        #1;
        force_sample = 1'b0;
        chk(tag, sensor_start, 1);
    endtask

    // Drive ready so that it is sampled on the k-th edge after the start edge.
    task automatic respond(input int k, input logic [7:0] t, input logic [7:0] h);
        repeat (k - 1) @(posedge clk);
        #1;
        sensor_temp  = t;
        sensor_hum   = h;
        sensor_ready = 1'b1;
        @(posedge clk);
        #1;
        sensor_ready = 1'b0;
    endtask

    task automatic sample(input string tag, input logic [7:0] t, input logic [7:0] h);
        int n;
        force_read({tag, "_start"});
        respond(3, t, h);
        wait_valid(n);
        chk({tag, "_dv_lat"}, n, 1);
    endtask

    initial begin
        int  n;
        bit  quiet;
        rst_n        = 1'b0;
        force_sample = 1'b0;
        sensor_ready = 1'b0;
        sensor_temp  = '0;
        sensor_hum   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {temp_out, hum_out, data_valid, sensor_fault, fan_on, hum_on, sensor_start}, 0);

        // 1: free-running period after release
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        n = -1;
        for (int i = 1; i <= 150; i++) begin
            @(posedge clk);
            #1;
            if (sensor_start) begin
                n = i;
                break;
            end
            if ({temp_out, hum_out, data_valid, sensor_fault, fan_on, hum_on} != 0) quiet = 1'b0;
        end
        chk("first_start_cycles", n, 100);
        chk("quiet_before_start", quiet, 1);

        // Reset while the first read is pending
        rst_n = 1'b0;
        #1;
        chk("rst_mid_read_start", sensor_start, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2: forced read, dwell preloaded so both actuators switch
        force_read("t2_start");
        respond(5, 8'd30, 8'd40);
        wait_valid(n);
        chk("t2_dv_lat", n, 1);
        chk("t2_temp", temp_out, 30);
        chk("t2_hum", hum_out, 40);
        chk("t2_fan", fan_on, 1);
        chk("t2_humon", hum_on, 1);
        @(posedge clk);
        #1;
        chk("t2_dv_one_cycle", data_valid, 0);

        // 3: hysteresis band, then dwell-blocked turn-off, then turn-off
        sample("t3a", 8'd26, 8'd40);
        chk("t3a_fan", fan_on, 1);
        sample("t3b", 8'd24, 8'd40);
        chk("t3b_fan_blocked", fan_on, 1);
        sample("t3c", 8'd24, 8'd40);
        chk("t3c_fan_off", fan_on, 0);
        chk("t3c_hum_on", hum_on, 1);

        // 4: three timeouts -> fault and fail-safe
        force_read("t4_start1");
        wait_start(n);
        chk("t4_retry_spacing1", n, 31);
        wait_start(n);
        chk("t4_retry_spacing2", n, 31);
        chk("t4_no_fault_yet", sensor_fault, 0);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (sensor_fault) begin
                n = i;
                break;
            end
        end
        chk("t4_fault_after_timeout", n, 21);
        chk("t4_failsafe_fan", fan_on, 1);
        chk("t4_failsafe_hum", hum_on, 0);
        chk("t4_temp_kept", temp_out, 24);
        chk("t4_hum_kept", hum_out, 40);
        wait_start(n);
        chk("t4_gap_after_fault", n, 10);
        respond(3, 8'd20, 8'd60);
        wait_valid(n);
        chk("t4_recover_dv", n, 1);
        chk("t4_fault_cleared", sensor_fault, 0);
        chk("t4_fan_off", fan_on, 0);
        chk("t4_temp_new", temp_out, 20);

        // 5: out-of-range readings are failures, retried after the gap
        force_read("t5_start");
        respond(3, 8'd60, 8'd40);
        dv_seen = 1'b0;
        wait_start(n);
        chk("t5_retry_hot", n, 11);
        respond(3, 8'd30, 8'd95);
        wait_start(n);
        chk("t5_retry_wet", n, 11);
        chk("t5_no_dv", dv_seen, 0);
        chk("t5_temp_kept", temp_out, 20);
        chk("t5_no_fault", sensor_fault, 0);
        respond(3, 8'd25, 8'd50);
        wait_valid(n);
        chk("t5_accept_dv", n, 1);
        chk("t5_temp", temp_out, 25);
        chk("t5_hum", hum_out, 50);

        // 6: two timeouts, then ready on the timeout cycle must win
        force_read("t6_start");
        wait_start(n);
        chk("t6_retry1", n, 31);
        wait_start(n);
        chk("t6_retry2", n, 31);
        respond(21, 8'd30, 8'd40);
        chk("t6_no_fault", sensor_fault, 0);
        wait_valid(n);
        chk("t6_dv", n, 1);
        chk("t6_temp", temp_out, 30);
        chk("t6_fan_blocked", fan_on, 0);
        chk("t6_hum_on", hum_on, 1);

        // sensor_ready outside BUSY is ignored
        dv_seen = 1'b0;
        respond(1, 8'd10, 8'd30);
        repeat (4) begin
            @(posedge clk);
            #1;
            if (data_valid) dv_seen = 1'b1;
        end
        chk("idle_ready_ignored", dv_seen, 0);
        chk("idle_temp_kept", temp_out, 30);

        // Reset in the middle of BUSY
        force_read("rst_busy_start");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_busy_outputs", {temp_out, hum_out, data_valid, sensor_fault, fan_on, hum_on, sensor_start}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        force_read("post_rst_force");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/coldstore_sample_ctrl.md
Name: coldstore_sample_ctrl

Overview:
Sequencer and climate controller between the DHT11 reader and the UART/LCD/actuator outputs. It triggers periodic sensor reads and enforces a read timeout with retries. It range-checks and latches readings, publishes them with a valid strobe, and drives the fan and humidifier through hysteresis with a minimum dwell. Repeated read failures raise a fault and force a fail-safe actuator state.

Parameters:
SAMPLE_CYC, 200_000_000, cycles between read starts (2 s at 100 MHz)
TIMEOUT_CYC, 3_000_000, max cycles from sensor_start to sensor_ready
RETRY_GAP_CYC, 100_000_000, wait before retrying a failed read
MAX_FAIL, 3, consecutive failures that assert sensor_fault
TEMP_SET, 8'd25, temperature setpoint (deg C)
TEMP_HYST, 8'd2, fan turn-on margin above TEMP_SET
HUM_SET, 8'd50, humidity setpoint (%RH)
HUM_HYST, 8'd5, humidifier turn-on margin below HUM_SET
MIN_DWELL, 2, accepted samples an actuator must hold its state before it may toggle

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
force_sample  in  1  one-cycle request to start a read immediately when idle
sensor_start  out  1  one-cycle pulse that starts a DHT11 read
sensor_ready  in  1  one-cycle pulse: reader finished, data stable
sensor_temp  in  8  reader temperature, integer deg C
sensor_hum  in  8  reader humidity, integer %RH
temp_out  out  8  last accepted temperature
hum_out  out  8  last accepted humidity
data_valid  out  1  one-cycle pulse when temp_out/hum_out are updated
sensor_fault  out  1  sticky until the next accepted sample
fan_on  out  1  cooling fan command
hum_on  out  1  humidifier command

Behaviour:
- Reset values, applied asynchronously on rst_n=0:
  - all outputs 0; state=WAIT; period counter=0.
  - fail count=0; both dwell counters=MIN_DWELL, so the first accepted sample may toggle either actuator.
- FSM states: WAIT, START, BUSY, CHECK, GAP.
- WAIT: period counter increments each cycle. Go to START when the counter reaches SAMPLE_CYC-1, or when force_sample=1. Clear the counter on exit. force_sample is ignored in all other states.
- START: assert sensor_start for exactly 1 cycle, clear the timeout counter, go to BUSY.
- BUSY: timeout counter increments each cycle.
  - sensor_ready=1 -> capture sensor_temp/sensor_hum into holding registers, go to CHECK.
  - Counter reaches TIMEOUT_CYC-1 with no ready -> failure, go to GAP.
  - Ready and timeout in the same cycle -> ready wins.
  - sensor_ready outside BUSY is ignored.
- CHECK (1 cycle): a sample is accepted iff temp<=50 and 20<=hum<=90 (DHT11 range).
  - Accepted: next cycle, temp_out/hum_out load, data_valid pulses for 1 cycle, fail count=0, sensor_fault=0, actuator update runs. Go to WAIT.
  - Rejected: failure, go to GAP.
- Failure handling: fail count increments, saturating at MAX_FAIL. When it reaches MAX_FAIL:
  - sensor_fault=1, fan_on=1, hum_on=0 (fail-safe, bypasses dwell); dwell counters reset to 0.
  - temp_out/hum_out keep their last accepted values; data_valid stays 0.
- GAP: wait RETRY_GAP_CYC cycles, then go to START. The periodic counter restarts only from WAIT.
- Actuator update, on accepted samples only; compares use 9-bit unsigned sums (no wrap):
  - fan: turns on if temp > TEMP_SET+TEMP_HYST; turns off if temp < TEMP_SET; otherwise holds.
  - humidifier: turns on if hum + HUM_HYST < HUM_SET; turns off if hum > HUM_SET; otherwise holds.
  - Dwell: each actuator has a counter that increments (saturating at MIN_DWELL) per accepted sample that does not toggle it. A toggle is allowed only when the counter >= MIN_DWELL; the counter clears to 0 on toggle. A blocked toggle leaves the state unchanged and the counter still increments.
- Actuator outputs change in the same cycle as data_valid.
- Reset mid-read: all state is discarded; after release the first read occurs SAMPLE_CYC cycles later, or on force_sample.

Test Plan (bench uses SAMPLE_CYC=100, TIMEOUT_CYC=20, RETRY_GAP_CYC=10, MAX_FAIL=3, MIN_DWELL=2, other defaults):
1. Reset release, no force -> sensor_start first pulses 100 cycles after release; all outputs 0 until then.
2. force_sample; reader replies ready after 5 cycles with temp=30, hum=40 -> data_valid pulse; temp_out=30, hum_out=40; fan_on=1, hum_on=1 (dwell preloaded).
3. Accepted samples temp=26 then 24 then 24 -> fan stays 1 on 26 (hysteresis band); sample 24 with dwell=1 is blocked; next 24 turns the fan off.
4. No sensor_ready three times -> sensor_start pulses 20+10 cycles apart. After the third timeout: sensor_fault=1, fan_on=1, hum_on=0, temp_out unchanged. Next valid sample (temp=20, hum=60) -> fault clears, fan_on=0.
5. Ready with temp=60 or hum=95 -> no data_valid, failure counted, retry start 10 cycles later.
6. sensor_ready in the same cycle the timeout expires -> sample accepted, no failure counted. rst_n low mid-BUSY -> outputs 0 immediately.
